// File: rtl/se_sram_pkg.sv
// -----------------------------------------------------------------------------
// se_sram_pkg
//   Shared types and helpers for the se_sram_srw_bwe_clr family.
//   - clr_state_e : clear sequencer states
//   - lanes       : write-enable lanes for the default 16-bit / 8-bit geometry
//   - calc_lanes  : lane count for any geometry
//   - params_ok   : elaboration-time legality check of the geometry/latency
// -----------------------------------------------------------------------------
package se_sram_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  localparam int unsigned default_data_width = 16;
  localparam int unsigned default_lane_width = 8;
  localparam int unsigned lanes = default_data_width / default_lane_width;

  function automatic int unsigned calc_lanes(input int unsigned data_width,
                                             input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

  // Word must split into whole lanes, and only two read pipelines exist.
  function automatic bit params_ok(input int unsigned data_width,
                                   input int unsigned lane_width,
                                   input int unsigned read_latency);
    return (lane_width != 0) && (data_width % lane_width == 0) &&
           (read_latency == 1 || read_latency == 2);
  endfunction

endpackage

// File: rtl/se_sram_srw_lane_array.sv
// -----------------------------------------------------------------------------
// se_sram_srw_lane_array
//   Raw single-port storage: 2**address_width words of data_width bits,
//   written per lane, read through one output register.
//   The initfile name travels with the array for simulation models that
//   preload mem_q hierarchically; the clear sequencer overwrites any image.
// Ports
//   clk      in   clock, rising edge
//   ce       in   clock enable; low holds every register and the array
//   rst      in   synchronous active-high reset of the read register only
//   wr_en    in   write this cycle (lanes selected by lane_we)
//   rd_en    in   read this cycle (result in rd_data after the edge)
//   lane_we  in   per-lane write enables, lane 0 = bits lane_width-1:0
//   addr     in   word address
//   wdata    in   write data
//   rd_data  out  registered read data; holds until the next read
// -----------------------------------------------------------------------------
module se_sram_srw_lane_array
  import se_sram_pkg::*;
#(
  parameter int unsigned address_width = 16,
  parameter int unsigned data_width    = 16,
  parameter int unsigned lane_width    = 8,
  parameter string       initfile      = ""
) (
  input  logic                                clk,
  input  logic                                ce,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic [data_width/lane_width-1:0]    lane_we,
  input  logic [address_width-1:0]            addr,
  input  logic [data_width-1:0]               wdata,
  output logic [data_width-1:0]               rd_data
);

  localparam int unsigned n_lanes = calc_lanes(data_width, lane_width);
  localparam int unsigned depth   = 2 ** address_width;

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] rd_data_q, rd_data_d;

  // NOTE: the storage array has no reset branch; resetting it would turn the
  // RAM into a flop bank. Known contents come from the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (ce && wr_en) begin
      for (int i = 0; i < n_lanes; i++) begin
        if (lane_we[i]) begin
          // NOTE: non-blocking so the write lands after every reader of this
          // edge has sampled the old word.
          mem_q[addr][i*lane_width +: lane_width] <= wdata[i*lane_width +: lane_width];
        end
      end
    end
  end

  // NOTE: rd_data_d gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rst) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      rd_data_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/se_sram_srw_bwe_clr.sv
// -----------------------------------------------------------------------------
// se_sram_srw_bwe_clr
//   Single-port synchronous SRAM with byte-lane write enables, read latency of
//   1 or 2 enabled cycles, and a clear sequencer that fills every word with
//   clear_value after reset (when clear_on_reset = 1).
// Ports
//   sram_clock          in   clock, rising edge
//   sram_clock__enable  in   clock enable; low = all registers and array hold
//   int_reset           in   synchronous active-high reset (needs enable high)
//   select              in   access request
//   read_not_write      in   1 = read, 0 = write
//   write_enable        in   per-lane write enables
//   address             in   word address
//   write_data          in   write data
//   data_out            out  read data, holds the last completed read
//   data_out_valid      out  one-enabled-cycle pulse per completed read
//   init_busy           out  clear sequencer running; requests are ignored
// -----------------------------------------------------------------------------
module se_sram_srw_bwe_clr
  import se_sram_pkg::*;
#(
  parameter int unsigned          address_width  = 16,
  parameter int unsigned          data_width     = 16,
  parameter int unsigned          lane_width     = 8,
  parameter int unsigned          read_latency   = 1,
  parameter bit                   clear_on_reset = 1'b1,
  parameter logic [data_width-1:0] clear_value   = '0,
  parameter string                initfile       = ""
) (
  input  logic                             sram_clock,
  input  logic                             sram_clock__enable,
  input  logic                             int_reset,
  input  logic                             select,
  input  logic                             read_not_write,
  input  logic [data_width/lane_width-1:0] write_enable,
  input  logic [address_width-1:0]         address,
  input  logic [data_width-1:0]            write_data,
  output logic [data_width-1:0]            data_out,
  output logic                             data_out_valid,
  output logic                             init_busy
);

  localparam int unsigned n_lanes = calc_lanes(data_width, lane_width);
  localparam logic [address_width-1:0] last_addr = '1;

  if (!params_ok(data_width, lane_width, read_latency)) begin : g_bad_params
    $error("se_sram_srw_bwe_clr: data_width must be a multiple of lane_width and read_latency must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  clr_state_e               state_q, state_d;
  logic [address_width-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (int_reset) begin
      state_d = clear_on_reset ? CLEARING : IDLE;
      count_d = '0;
    end else if (state_q == CLEARING) begin
      // The last word is written on the same edge that leaves CLEARING, so the
      // whole clear takes exactly depth enabled cycles. The counter wraps to 0.
      count_d = count_q + 1'b1;
      if (count_q == last_addr) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_clock__enable) begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign init_busy = (state_q == CLEARING);

  // ---------------------------------------------------------------------------
  // Port mux: the clear sequencer owns the array while it runs; user requests
  // are dropped. Nothing reaches the array on a reset cycle.
  // ---------------------------------------------------------------------------
  logic                         arr_wr_en;
  logic                         arr_rd_en;
  logic [n_lanes-1:0]           arr_lane_we;
  logic [address_width-1:0]     arr_addr;
  logic [data_width-1:0]        arr_wdata;
  logic [data_width-1:0]        arr_rdata;

  always_comb begin
    arr_wr_en   = 1'b0;
    arr_rd_en   = 1'b0;
    arr_lane_we = write_enable;
    arr_addr    = address;
    arr_wdata   = write_data;
    if (!int_reset) begin
      if (state_q == CLEARING) begin
        arr_wr_en   = 1'b1;
        arr_lane_we = '1;
        arr_addr    = count_q;
        arr_wdata   = clear_value;
      end else if (select) begin
        arr_wr_en = !read_not_write;
        arr_rd_en = read_not_write;
      end
    end
  end

  se_sram_srw_lane_array #(
    .address_width (address_width),
    .data_width    (data_width),
    .lane_width    (lane_width),
    .initfile      (initfile)
  ) u_array (
    .clk     (sram_clock),
    .ce      (sram_clock__enable),
    .rst     (int_reset),
    .wr_en   (arr_wr_en),
    .rd_en   (arr_rd_en),
    .lane_we (arr_lane_we),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .rd_data (arr_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read-valid pipeline: stage 1 tracks the array's read register.
  // ---------------------------------------------------------------------------
  logic rd_valid_q, rd_valid_d;

  // arr_rd_en is already forced low on reset cycles, which flushes the stage.
  assign rd_valid_d = arr_rd_en;

  always_ff @(posedge sram_clock) begin
    if (sram_clock__enable) begin
      rd_valid_q <= rd_valid_d;
    end
  end

  if (read_latency == 2) begin : g_lat2
    logic [data_width-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // The output register only loads when stage 1 holds a completed read, so
    // data_out keeps the last read word between reads.
    always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = rd_valid_q;
      if (int_reset) begin
        out_data_d  = '0;
        out_valid_d = 1'b0;
      end else if (rd_valid_q) begin
        out_data_d = arr_rdata;
      end
    end

    always_ff @(posedge sram_clock) begin
      if (sram_clock__enable) begin
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign data_out       = out_data_q;
    assign data_out_valid = out_valid_q;
  end else begin : g_lat1
    assign data_out       = arr_rdata;
    assign data_out_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_se_sram_srw_bwe_clr.sv
// -----------------------------------------------------------------------------
// tb_se_sram_srw_bwe_clr
//   Two 16x16 instances share one stimulus stream: u_lat1 (read_latency 1) and
//   u_lat2 (read_latency 2), both clearing to 16'hA5A5 after reset.
// -----------------------------------------------------------------------------
module tb_se_sram_srw_bwe_clr;

  logic        clk = 1'b0;
  logic        ce;
  logic        rst;
  logic        sel;
  logic        rnw;
  logic [1:0]  we;
  logic [3:0]  addr;
  logic [15:0] wdata;

  logic [15:0] d1, d2;
  logic        v1, v2, b1, b2;

  int checks   = 0;
  int failures = 0;
  int n_clear;
  int pre;

  always #5 clk = ~clk;

  se_sram_srw_bwe_clr #(
    .address_width (4),
    .data_width    (16),
    .lane_width    (8),
    .read_latency  (1),
    .clear_on_reset(1'b1),
    .clear_value   (16'hA5A5)
  ) u_lat1 (
    .sram_clock        (clk),
    .sram_clock__enable(ce),
    .int_reset         (rst),
    .select            (sel),
    .read_not_write    (rnw),
    .write_enable      (we),
    .address           (addr),
    .write_data        (wdata),
    .data_out          (d1),
    .data_out_valid    (v1),
    .init_busy         (b1)
  );

  se_sram_srw_bwe_clr #(
    .address_width (4),
    .data_width    (16),
    .lane_width    (8),
    .read_latency  (2),
    .clear_on_reset(1'b1),
    .clear_value   (16'hA5A5)
  ) u_lat2 (
    .sram_clock        (clk),
    .sram_clock__enable(ce),
    .int_reset         (rst),
    .select            (sel),
    .read_not_write    (rnw),
    .write_enable      (we),
    .address           (addr),
    .write_data        (wdata),
    .data_out          (d2),
    .data_out_valid    (v2),
    .init_busy         (b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sel = 1'b0; rnw = 1'b0; we = 2'b00; addr = 4'd0; wdata = 16'h0000;
  endtask

  task automatic rd(input logic [3:0] a);
    sel = 1'b1; rnw = 1'b1; we = 2'b00; addr = a;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] w);
    sel = 1'b1; rnw = 1'b0; we = w; addr = a; wdata = d;
  endtask

  // Counts enabled edges until init_busy drops, bounded.
  task automatic wait_clear(input string tag, output int n);
    int guard;
    bit en;
    n = 0;
    guard = 0;
    while (b1 && guard < 64) begin
      en = ce;
      tick();
      guard++;
      if (en) n++;
    end
    if (b1) check({tag, "_timeout"}, 32'(b1), 32'd0);
  endtask

  initial begin
    ce = 1'b1;
    rst = 1'b0;
    idle_in();
    #2;

    // ---- Test 1: reset, clear length, readback of clear value ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_d1", 32'(d1), 32'h0);
    check("rst_v1", 32'(v1), 32'h0);
    check("rst_busy1", 32'(b1), 32'h1);
    check("rst_d2", 32'(d2), 32'h0);
    check("rst_v2", 32'(v2), 32'h0);
    check("rst_busy2", 32'(b2), 32'h1);
    wait_clear("clear1", n_clear);
    check("clear1_cycles", 32'(n_clear), 32'd16);
    check("clear1_busy2", 32'(b2), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      tick();
      check($sformatf("clr_rd%0d_d", i), 32'(d1), 32'hA5A5);
      check($sformatf("clr_rd%0d_v", i), 32'(v1), 32'h1);
    end
    idle_in();
    tick();
    check("after_rd_v1", 32'(v1), 32'h0);
    check("after_rd_hold1", 32'(d1), 32'hA5A5);
    check("after_rd_v2", 32'(v2), 32'h1);
    check("after_rd_d2", 32'(d2), 32'hA5A5);

    // ---- Test 2: byte lanes ----
    wr(4'd3, 16'h1234, 2'b11);
    tick();
    wr(4'd3, 16'hABCD, 2'b01);
    tick();
    rd(4'd3);
    tick();
    check("lane_d1", 32'(d1), 32'h12CD);
    idle_in();
    tick();
    check("lane_d2", 32'(d2), 32'h12CD);
    check("lane_v2", 32'(v2), 32'h1);

    // ---- Test 6: write then read next cycle; empty lane mask ----
    wr(4'd5, 16'h0F0F, 2'b11);
    tick();
    check("wr_no_valid", 32'(v1), 32'h0);
    rd(4'd5);
    tick();
    check("wr_rd_d1", 32'(d1), 32'h0F0F);
    check("wr_rd_v1", 32'(v1), 32'h1);
    wr(4'd5, 16'hFFFF, 2'b00);
    tick();
    rd(4'd5);
    tick();
    check("we0_noop", 32'(d1), 32'h0F0F);
    idle_in();
    tick();

    // ---- Test 3: latency-2 streaming ----
    wr(4'd0, 16'h1111, 2'b11); tick();
    wr(4'd1, 16'h2222, 2'b11); tick();
    wr(4'd2, 16'h3333, 2'b11); tick();
    rd(4'd0); tick();
    check("l2_c1_v", 32'(v2), 32'h0);
    rd(4'd1); tick();
    check("l2_c2_v", 32'(v2), 32'h1);
    check("l2_c2_d", 32'(d2), 32'h1111);
    rd(4'd2); tick();
    check("l2_c3_v", 32'(v2), 32'h1);
    check("l2_c3_d", 32'(d2), 32'h2222);
    idle_in(); tick();
    check("l2_c4_v", 32'(v2), 32'h1);
    check("l2_c4_d", 32'(d2), 32'h3333);
    tick();
    check("l2_c5_v", 32'(v2), 32'h0);
    check("l2_c5_hold", 32'(d2), 32'h3333);

    // ---- Test 4a: enable low mid-read ----
    rd(4'd1);
    tick();
    idle_in();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ce_lo%0d_v2", i), 32'(v2), 32'h0);
      check($sformatf("ce_lo%0d_d2", i), 32'(d2), 32'h3333);
      check($sformatf("ce_lo%0d_v1", i), 32'(v1), 32'h1);
      check($sformatf("ce_lo%0d_d1", i), 32'(d1), 32'h2222);
    end
    ce = 1'b1;
    tick();
    check("ce_resume_v2", 32'(v2), 32'h1);
    check("ce_resume_d2", 32'(d2), 32'h2222);
    check("ce_resume_v1", 32'(v1), 32'h0);

    // ---- Test 4b: enable low mid-clear ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("clr_ce_lo%0d_busy", i), 32'(b1), 32'h1);
      check($sformatf("clr_ce_lo%0d_d1", i), 32'(d1), 32'h0);
    end
    ce = 1'b1;
    wait_clear("clear2", n_clear);
    check("clear2_cycles", 32'(5 + n_clear), 32'd16);

    // ---- Test 5: reset at counter 7, requests during clear ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("restart_busy", 32'(b1), 32'h1);
    wr(4'd15, 16'h7777, 2'b11);
    tick();
    check("clr_wr_v1", 32'(v1), 32'h0);
    rd(4'd15);
    tick();
    check("clr_rd_v1", 32'(v1), 32'h0);
    check("clr_rd_v2", 32'(v2), 32'h0);
    check("clr_rd_d1", 32'(d1), 32'h0);
    pre = 2;
    wait_clear("clear3", n_clear);
    check("clear3_cycles", 32'(pre + n_clear), 32'd16);
    rd(4'd15);
    tick();
    check("post_clr_15", 32'(d1), 32'hA5A5);
    rd(4'd3);
    tick();
    check("post_clr_3", 32'(d1), 32'hA5A5);
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
